// File: rtl/mod_exp.sv
// mod_exp: word-serial modular exponentiation C = M^E mod N.
// Uses Montgomery multiplication (CIOS) with radix 2^DATA_WIDTH and one
// DATA_WIDTH x DATA_WIDTH product per cycle. DATA_WIDTH and WORDS must both be
// powers of two, each at least 2.
// Ports:
//   clk, reset (async, active low)
//   m_buf/e_buf/n_buf/r_buf/t_buf : operand word streams, LS word first
//   nprime0                       : -N^-1 mod 2^DATA_WIDTH
//   startInput / getResult        : begin load / end-of-load marker
//   startCompute                  : compute start and output enable
//   exp_state, state              : top FSM and Montgomery sub-FSM codes
//   res_out                       : result word stream
module mod_exp #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned WORDS      = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] m_buf,
    input  logic [DATA_WIDTH-1:0] e_buf,
    input  logic [DATA_WIDTH-1:0] n_buf,
    input  logic [DATA_WIDTH-1:0] r_buf,
    input  logic [DATA_WIDTH-1:0] t_buf,
    input  logic [DATA_WIDTH-1:0] nprime0,
    input  logic                  startInput,
    input  logic                  startCompute,
    input  logic                  getResult,
    output logic [4:0]            exp_state,
    output logic [3:0]            state,
    output logic [DATA_WIDTH-1:0] res_out
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam int unsigned LOG_D = $clog2(DATA_WIDTH);
    localparam int unsigned BIT_W = $clog2(WORDS * DATA_WIDTH);

    typedef enum logic [4:0] {
        INIT_STATE       = 5'd0,
        LOAD_M_E         = 5'd1,
        LOAD_N           = 5'd2,
        WAIT_COMPUTE     = 5'd3,
        CALC_M_BAR       = 5'd4,
        GET_K_E          = 5'd5,
        BIGLOOP          = 5'd6,
        CALC_C_BAR_M_BAR = 5'd7,
        CALC_C_BAR_1     = 5'd8,
        COMPLETE         = 5'd9,
        OUTPUT_RESULT    = 5'd10,
        TERMINAL         = 5'd11
    } exp_state_t;

    typedef enum logic [3:0] {
        MM_IDLE  = 4'd0,
        MM_MUL   = 4'd1,
        MM_RED   = 4'd2,
        MM_SHIFT = 4'd3,
        MM_SUB   = 4'd4,
        MM_DONE  = 4'd5
    } mm_state_t;

    exp_state_t exp_cur, exp_nxt;
    mm_state_t  mm_cur, mm_nxt;

    // Operand shift registers and intermediate Montgomery-domain values
    logic [DW-1:0] m_reg [WORDS];
    logic [DW-1:0] e_reg [WORDS];
    logic [DW-1:0] n_reg [WORDS];
    logic [DW-1:0] r_reg [WORDS];
    logic [DW-1:0] t_reg [WORDS];
    logic [DW-1:0] m_bar [WORDS];
    logic [DW-1:0] c_bar [WORDS];

    // CIOS accumulator: WORDS low words plus two overflow words
    logic [DW-1:0] t_lo [WORDS];
    logic [DW-1:0] t_hi;
    logic [DW-1:0] t_top;
    logic [DW-1:0] d_reg [WORDS];

    logic [IDX_W-1:0] mm_i, mm_j, out_idx;
    logic             q_phase, borrow, out_done;
    logic [DW-1:0]    q_reg, carry;
    logic [BIT_W-1:0] bit_idx;

    logic [DW-1:0]   a_word_c, b_word_c, mul_x_c, mul_y_c;
    logic            mm_go_c, mm_done_c, e_bit_c, use_diff_c, j_last_c;
    logic [2*DW-1:0] prod_c, acc_sum_c;
    logic [DW:0]     top_sum_c, sub_c;

    assign exp_state = exp_cur;
    assign state     = mm_cur;

    // Shared datapath arithmetic
    assign prod_c     = (2*DW)'(mul_x_c) * (2*DW)'(mul_y_c);
    assign acc_sum_c  = (2*DW)'(t_lo[mm_j]) + prod_c + (2*DW)'(carry);
    assign top_sum_c  = (DW+1)'(t_hi) + (DW+1)'(acc_sum_c[2*DW-1:DW]);
    assign sub_c      = (DW+1)'(t_lo[mm_j]) - (DW+1)'(n_reg[mm_j]) - (DW+1)'(borrow);
    assign use_diff_c = t_hi[0] | ~borrow;
    assign j_last_c   = (mm_j == IDX_W'(WORDS - 1));

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_cur <= INIT_STATE;
            mm_cur  <= MM_IDLE;
        end else begin
            exp_cur <= exp_nxt;
            mm_cur  <= mm_nxt;
        end
    end

    // Next-state logic for both FSMs
    always_comb begin
        exp_nxt = exp_cur;
        mm_nxt  = mm_cur;
        case (exp_cur)
            INIT_STATE:       if (startInput) exp_nxt = LOAD_M_E;
            LOAD_M_E:         if (getResult) exp_nxt = WAIT_COMPUTE;
            WAIT_COMPUTE:     if (startCompute) exp_nxt = CALC_M_BAR;
            CALC_M_BAR:       if (mm_done_c) exp_nxt = GET_K_E;
            GET_K_E: begin
                if (e_bit_c)              exp_nxt = BIGLOOP;
                else if (bit_idx == '0)   exp_nxt = CALC_C_BAR_1;
            end
            BIGLOOP: begin
                if (mm_done_c) begin
                    if (e_bit_c)            exp_nxt = CALC_C_BAR_M_BAR;
                    else if (bit_idx == '0) exp_nxt = CALC_C_BAR_1;
                end
            end
            CALC_C_BAR_M_BAR: begin
                if (mm_done_c) exp_nxt = (bit_idx == '0) ? CALC_C_BAR_1 : BIGLOOP;
            end
            CALC_C_BAR_1:     if (mm_done_c) exp_nxt = COMPLETE;
            COMPLETE:         if (startCompute) exp_nxt = OUTPUT_RESULT;
            OUTPUT_RESULT:    if (out_done) exp_nxt = TERMINAL;
            TERMINAL:         if (!startInput) exp_nxt = INIT_STATE;
            default:          exp_nxt = INIT_STATE;
        endcase

        case (mm_cur)
            MM_IDLE:  if (mm_go_c) mm_nxt = MM_MUL;
            MM_MUL:   if (j_last_c) mm_nxt = MM_RED;
            MM_RED:   if (!q_phase && j_last_c) mm_nxt = MM_SHIFT;
            MM_SHIFT: mm_nxt = (mm_i == IDX_W'(WORDS - 1)) ? MM_SUB : MM_MUL;
            MM_SUB:   if (j_last_c) mm_nxt = MM_DONE;
            MM_DONE:  mm_nxt = MM_IDLE;
            default:  mm_nxt = MM_IDLE;
        endcase
    end

    // Control strobes and multiplier operand selection
    always_comb begin
        a_word_c  = c_bar[mm_i];
        b_word_c  = '0;
        mul_x_c   = '0;
        mul_y_c   = '0;
        mm_go_c   = 1'b0;
        mm_done_c = (mm_cur == MM_DONE);
        e_bit_c   = e_reg[bit_idx[BIT_W-1:LOG_D]][bit_idx[LOG_D-1:0]];

        case (exp_cur)
            CALC_M_BAR: begin
                a_word_c = m_reg[mm_i];
                b_word_c = t_reg[mm_j];
                mm_go_c  = (mm_cur == MM_IDLE);
            end
            BIGLOOP: begin
                b_word_c = c_bar[mm_j];
                mm_go_c  = (mm_cur == MM_IDLE);
            end
            CALC_C_BAR_M_BAR: begin
                b_word_c = m_bar[mm_j];
                mm_go_c  = (mm_cur == MM_IDLE);
            end
            CALC_C_BAR_1: begin
                b_word_c = (mm_j == '0) ? DW'(1) : '0;
                mm_go_c  = (mm_cur == MM_IDLE);
            end
            default: ;
        endcase

        // First RED cycle derives q from T0; later cycles accumulate q*N
        case (mm_cur)
            MM_MUL: begin
                mul_x_c = a_word_c;
                mul_y_c = b_word_c;
            end
            MM_RED: begin
                mul_x_c = q_phase ? t_lo[0] : q_reg;
                mul_y_c = q_phase ? nprime0 : n_reg[mm_j];
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < WORDS; k++) begin
                m_reg[k] <= '0;
                e_reg[k] <= '0;
                n_reg[k] <= '0;
                r_reg[k] <= '0;
                t_reg[k] <= '0;
                m_bar[k] <= '0;
                c_bar[k] <= '0;
                t_lo[k]  <= '0;
                d_reg[k] <= '0;
            end
            t_hi     <= '0;
            t_top    <= '0;
            mm_i     <= '0;
            mm_j     <= '0;
            out_idx  <= '0;
            q_phase  <= 1'b0;
            borrow   <= 1'b0;
            out_done <= 1'b0;
            q_reg    <= '0;
            carry    <= '0;
            bit_idx  <= '0;
            res_out  <= '0;
        end else begin
            // New word enters at the MS position
            if (exp_cur == LOAD_M_E && !getResult) begin
                for (int unsigned k = 0; k < WORDS - 1; k++) begin
                    m_reg[k] <= m_reg[k+1];
                    e_reg[k] <= e_reg[k+1];
                    n_reg[k] <= n_reg[k+1];
                    r_reg[k] <= r_reg[k+1];
                    t_reg[k] <= t_reg[k+1];
                end
                m_reg[WORDS-1] <= m_buf;
                e_reg[WORDS-1] <= e_buf;
                n_reg[WORDS-1] <= n_buf;
                r_reg[WORDS-1] <= r_buf;
                t_reg[WORDS-1] <= t_buf;
            end

            // Montgomery multiplier
            case (mm_cur)
                MM_IDLE: begin
                    if (mm_go_c) begin
                        for (int unsigned k = 0; k < WORDS; k++) t_lo[k] <= '0;
                        t_hi  <= '0;
                        t_top <= '0;
                        mm_i  <= '0;
                        mm_j  <= '0;
                        carry <= '0;
                    end
                end
                MM_MUL: begin
                    t_lo[mm_j] <= acc_sum_c[DW-1:0];
                    carry      <= acc_sum_c[2*DW-1:DW];
                    mm_j       <= mm_j + IDX_W'(1);
                    if (j_last_c) begin
                        t_hi    <= top_sum_c[DW-1:0];
                        t_top   <= DW'(top_sum_c[DW]);
                        q_phase <= 1'b1;
                        carry   <= '0;
                    end
                end
                MM_RED: begin
                    if (q_phase) begin
                        q_reg   <= prod_c[DW-1:0];
                        q_phase <= 1'b0;
                        carry   <= '0;
                    end else begin
                        t_lo[mm_j] <= acc_sum_c[DW-1:0];
                        carry      <= acc_sum_c[2*DW-1:DW];
                        mm_j       <= mm_j + IDX_W'(1);
                        if (j_last_c) begin
                            t_hi  <= top_sum_c[DW-1:0];
                            t_top <= t_top + DW'(top_sum_c[DW]);
                        end
                    end
                end
                MM_SHIFT: begin
                    // Word 0 is zero after reduction; drop it
                    for (int unsigned k = 0; k < WORDS - 1; k++) t_lo[k] <= t_lo[k+1];
                    t_lo[WORDS-1] <= t_hi;
                    t_hi          <= t_top;
                    t_top         <= '0;
                    mm_i          <= mm_i + IDX_W'(1);
                    mm_j          <= '0;
                    carry         <= '0;
                    borrow        <= 1'b0;
                end
                MM_SUB: begin
                    d_reg[mm_j] <= sub_c[DW-1:0];
                    borrow      <= sub_c[DW];
                    mm_j        <= mm_j + IDX_W'(1);
                end
                default: ;
            endcase

            // Exponentiation sequencing
            case (exp_cur)
                WAIT_COMPUTE: bit_idx <= BIT_W'(WORDS * DATA_WIDTH - 1);
                CALC_M_BAR: begin
                    if (mm_done_c) begin
                        for (int unsigned k = 0; k < WORDS; k++) begin
                            m_bar[k] <= use_diff_c ? d_reg[k] : t_lo[k];
                            c_bar[k] <= r_reg[k];
                        end
                    end
                end
                GET_K_E: begin
                    if (!e_bit_c && bit_idx != '0) bit_idx <= bit_idx - BIT_W'(1);
                end
                BIGLOOP: begin
                    if (mm_done_c) begin
                        for (int unsigned k = 0; k < WORDS; k++)
                            c_bar[k] <= use_diff_c ? d_reg[k] : t_lo[k];
                        if (!e_bit_c && bit_idx != '0) bit_idx <= bit_idx - BIT_W'(1);
                    end
                end
                CALC_C_BAR_M_BAR: begin
                    if (mm_done_c) begin
                        for (int unsigned k = 0; k < WORDS; k++)
                            c_bar[k] <= use_diff_c ? d_reg[k] : t_lo[k];
                        if (bit_idx != '0) bit_idx <= bit_idx - BIT_W'(1);
                    end
                end
                CALC_C_BAR_1: begin
                    if (mm_done_c) begin
                        for (int unsigned k = 0; k < WORDS; k++)
                            c_bar[k] <= use_diff_c ? d_reg[k] : t_lo[k];
                    end
                end
                COMPLETE: begin
                    out_idx  <= '0;
                    out_done <= 1'b0;
                end
                OUTPUT_RESULT: begin
                    // Entry edge is the dummy cycle; words follow on later edges
                    if (!out_done) begin
                        res_out <= c_bar[out_idx];
                        out_idx <= out_idx + IDX_W'(1);
                        if (out_idx == IDX_W'(WORDS - 1)) out_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp.sv
// Scoreboard bench for mod_exp with a reduced operand size (4 x 8-bit words).
module tb_mod_exp;

    localparam int unsigned DW  = 8;
    localparam int unsigned NW  = 4;
    localparam int unsigned OPW = DW * NW;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf, nprime0;
    logic          startInput, startCompute, getResult;
    logic [4:0]    exp_state;
    logic [3:0]    mm_state;
    logic [DW-1:0] res_out;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];

    mod_exp #(.DATA_WIDTH(DW), .WORDS(NW)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .m_buf        (m_buf),
        .e_buf        (e_buf),
        .n_buf        (n_buf),
        .r_buf        (r_buf),
        .t_buf        (t_buf),
        .nprime0      (nprime0),
        .startInput   (startInput),
        .startCompute (startCompute),
        .getResult    (getResult),
        .exp_state    (exp_state),
        .state        (mm_state),
        .res_out      (res_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic longint unsigned modexp(input longint unsigned m, input longint unsigned e,
                                               input longint unsigned n);
        longint unsigned res = 1 % n;
        longint unsigned b   = m % n;
        for (int i = 0; i < 32; i++) begin
            if (((e >> i) & 64'd1) != 0) res = (res * b) % n;
            b = (b * b) % n;
        end
        return res;
    endfunction

    // Load operands, then start computing; returns after COMPLETE is reached
    task automatic load_and_start(input logic [OPW-1:0] m, input logic [OPW-1:0] e,
                                  input logic [OPW-1:0] n, input bit hold_wait);
        longint unsigned r, t, inv, nn;
        logic [OPW-1:0] rv, tv;
        nn  = 64'(n);
        r   = (64'd1 << OPW) % nn;
        t   = (r * r) % nn;
        inv = nn;
        repeat (6) inv = inv * (64'd2 - nn * inv);
        rv  = OPW'(r);
        tv  = OPW'(t);
        nprime0 = DW'(64'd0 - inv);

        startInput = 1'b1;
        tick();
        startInput = 1'b0;
        check("enter_load", exp_state, 1);
        // filler word that must fall off the bottom
        m_buf = 8'hA5; e_buf = 8'h5A; n_buf = 8'hC3; r_buf = 8'h3C; t_buf = 8'h99;
        tick();
        for (int j = 0; j < NW; j++) begin
            m_buf = m[DW*j +: DW];
            e_buf = e[DW*j +: DW];
            n_buf = n[DW*j +: DW];
            r_buf = rv[DW*j +: DW];
            t_buf = tv[DW*j +: DW];
            tick();
        end
        getResult = 1'b1;
        tick();
        getResult = 1'b0;
        check("enter_wait", exp_state, 3);
        if (hold_wait) begin
            for (int c = 0; c < 10; c++) begin
                tick();
                check("hold_wait", exp_state, 3);
            end
        end
        startCompute = 1'b1;
    endtask

    task automatic run_case(input logic [OPW-1:0] m, input logic [OPW-1:0] e,
                            input logic [OPW-1:0] n, input logic [OPW-1:0] expected,
                            input bit hold_wait);
        int cnt;
        load_and_start(m, e, n, hold_wait);
        cnt = 0;
        while (exp_state != 5'd9 && cnt < 20000) begin
            tick();
            cnt++;
        end
        check("reach_complete", exp_state, 9);
        if (exp_state == 5'd9) begin
            check("mm_idle_at_complete", mm_state, 0);
            for (int j = 0; j < NW; j++) exp_q.push_back(expected[DW*j +: DW]);
            cnt = 0;
            while (exp_state != 5'd11 && cnt < NW + 10) begin
                tick();
                cnt++;
            end
            check("reach_terminal", exp_state, 11);
        end
        startInput = 1'b1;
        repeat (3) tick();
        startInput = 1'b0;
        tick();
        check("back_to_init", exp_state, 0);
        startCompute = 1'b0;
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: dummy cycle, NW result words, then a stable TERMINAL
    logic [4:0]    prev_st;
    logic [DW-1:0] prev_res;
    int            out_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_st = 5'd0;
            out_cnt = 0;
        end else begin
            if (prev_st != 5'd10 && exp_state == 5'd10) begin
                out_cnt = 0;
                check("dummy_cycle", res_out, prev_res);
            end else if (prev_st == 5'd10) begin
                if (out_cnt < NW) begin
                    check("sb_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) check($sformatf("res_word%0d", out_cnt), res_out, exp_q.pop_front());
                end else begin
                    check("terminal_entry", exp_state, 11);
                    check("terminal_entry_hold", res_out, prev_res);
                end
                out_cnt++;
            end else if (prev_st == 5'd11 && exp_state == 5'd11) begin
                check("terminal_hold", res_out, prev_res);
            end
        end
        prev_st  = exp_state;
        prev_res = res_out;
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        m_buf = '0; e_buf = '0; n_buf = '0; r_buf = '0; t_buf = '0; nprime0 = '0;
        startInput = 1'b0; startCompute = 1'b0; getResult = 1'b0;
        tick();
        check("reset_exp_state", exp_state, 0);
        check("reset_mm_state", mm_state, 0);
        check("reset_res_out", res_out, 0);
        tick();
        rst_n = 1'b1;
        tick();

        run_case(32'd8, 32'd13, 32'd77, 32'd50, 1'b1);
        run_case(32'd3, 32'd5,  32'd77, 32'd12, 1'b0);
        run_case(32'd5, 32'd1,  32'd77, 32'd5,  1'b0);
        run_case(32'd9, 32'd0,  32'd77, 32'd1,  1'b0);
        run_case(32'd0, 32'd7,  32'd77, 32'd0,  1'b0);
        run_case(32'h0000_1F2D, 32'h00F3_E7AF, 32'h0000_E3B1,
                 OPW'(modexp(64'h1F2D, 64'hF3E7AF, 64'hE3B1)), 1'b0);
        run_case(32'h1234_5679, 32'h00F3_E7AF, 32'hF1E2_D3C5,
                 OPW'(modexp(64'h1234_5679, 64'hF3E7AF, 64'hF1E2_D3C5)), 1'b0);

        // Abort during BIGLOOP with an asynchronous reset
        load_and_start(32'd8, 32'd13, 32'd77, 1'b0);
        cnt = 0;
        while (exp_state != 5'd6 && cnt < 5000) begin
            tick();
            cnt++;
        end
        check("reach_bigloop", exp_state, 6);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_exp_state", exp_state, 0);
        check("abort_mm_state", mm_state, 0);
        check("abort_res_out", res_out, 0);
        startCompute = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        run_case(32'd8, 32'd13, 32'd77, 32'd50, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
